// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD command controller: FSM states, command-word
// bit positions, the built-in init sequence and the slow-command classifier.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_ENHI,
        ST_HOLD,
        ST_WAIT
    } lcd_state_e;

    localparam int BIT_ON        = 31;
    localparam int BIT_BLON      = 30;
    localparam int BIT_CTRL_ONLY = 29;
    localparam int BIT_RS        = 8;

    localparam int INIT_LEN = 4;
    // Function set 8-bit/2-line, display on, clear, entry mode increment (index 0 first).
    localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38};

    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0) && (data != 8'd0);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// Small power-of-two command FIFO with extra-MSB pointers; read data is the head entry
// (show-ahead), so a pop and its data use the same cycle.
module lcd_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + (AW+1)'(1);
            if (pop && !empty) rptr <= rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push && !full) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: queues CPU LCD command words and replays each as a timed HD44780 write cycle.
// Define LCD_INIT_EN to add a power-up delay and built-in init sequence after reset.
module lcd_ctrl
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int T_SETUP_CYC = 4,
    parameter int T_EN_CYC    = 25,
    parameter int T_HOLD_CYC  = 2,
    parameter int T_CMD_CYC   = 2000,
    parameter int T_CLR_CYC   = 82000,
    parameter int T_PWRUP_CYC = 750000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_lcd_we,
    input  logic [31:0] i_lcd_word,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_lcd_blon,
    output logic        o_busy,
    output logic        o_full,
    output logic        o_overflow
);
    localparam int T_MAX = max_int(max_int(max_int(T_SETUP_CYC, T_EN_CYC),
                                           max_int(T_HOLD_CYC, T_CMD_CYC)),
                                   max_int(T_CLR_CYC, T_PWRUP_CYC));
    localparam int TW = $clog2(T_MAX + 1);

    localparam logic [TW-1:0] LD_SETUP = TW'(T_SETUP_CYC - 1);
    localparam logic [TW-1:0] LD_EN    = TW'(T_EN_CYC - 1);
    localparam logic [TW-1:0] LD_HOLD  = TW'(T_HOLD_CYC - 1);
    localparam logic [TW-1:0] LD_CMD   = TW'(T_CMD_CYC - 1);
    localparam logic [TW-1:0] LD_CLR   = TW'(T_CLR_CYC - 1);
`ifdef LCD_INIT_EN
    localparam logic [TW-1:0] LD_PWRUP = TW'(T_PWRUP_CYC - 1);
`endif

    lcd_state_e    state;
    logic [TW-1:0] timer;
    logic          req_q;
    logic [8:0]    req_word_q;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [8:0]    fifo_rdata;
    logic          force_on;
    logic          unused_word_bits;

    assign unused_word_bits = ^i_lcd_word[28:9];
    assign push     = req_q && !fifo_full;
    assign pop      = (state == ST_IDLE) && !fifo_empty;
    assign o_busy   = !fifo_empty || (state != ST_IDLE);
    assign o_full   = fifo_full;
    assign o_lcd_rw = 1'b0;

    lcd_cmd_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(9)
    ) u_fifo (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .push   (push),
        .wdata  (req_word_q),
        .pop    (pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Write decode: power/backlight update immediately; the FIFO push is staged one cycle.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            req_q      <= 1'b0;
            req_word_q <= '0;
            o_lcd_on   <= 1'b0;
            o_lcd_blon <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            req_q <= i_lcd_we && !i_lcd_word[BIT_CTRL_ONLY];
            if (i_lcd_we) begin
                req_word_q <= {i_lcd_word[BIT_RS], i_lcd_word[7:0]};
                o_lcd_on   <= i_lcd_word[BIT_ON] | force_on;
                o_lcd_blon <= i_lcd_word[BIT_BLON];
            end else if (force_on) begin
                o_lcd_on <= 1'b1;
            end
            if (req_q && fifo_full) o_overflow <= 1'b1;
        end
    end

`ifdef LCD_INIT_EN
    logic [1:0] init_idx;
    logic       init_done;
`else
    assign force_on = 1'b0;
`endif

    // Each timed state is entered with timer = count-1 and advances when timer reaches 0.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_lcd_en   <= 1'b0;
            o_lcd_data <= '0;
            o_lcd_rs   <= 1'b0;
`ifdef LCD_INIT_EN
            state      <= ST_PWRUP;
            timer      <= LD_PWRUP;
            init_idx   <= '0;
            init_done  <= 1'b0;
            force_on   <= 1'b0;
`else
            state      <= ST_IDLE;
            timer      <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        {o_lcd_rs, o_lcd_data} <= fifo_rdata;
                        state <= ST_SETUP;
                        timer <= LD_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (timer == '0) begin
                        state    <= ST_ENHI;
                        o_lcd_en <= 1'b1;
                        timer    <= LD_EN;
                    end else timer <= timer - TW'(1);
                end
                ST_ENHI: begin
                    if (timer == '0) begin
                        state    <= ST_HOLD;
                        o_lcd_en <= 1'b0;
                        timer    <= LD_HOLD;
                    end else timer <= timer - TW'(1);
                end
                ST_HOLD: begin
                    if (timer == '0) begin
                        state <= ST_WAIT;
                        timer <= is_slow_cmd(o_lcd_rs, o_lcd_data) ? LD_CLR : LD_CMD;
                    end else timer <= timer - TW'(1);
                end
                ST_WAIT: begin
                    if (timer == '0) begin
`ifdef LCD_INIT_EN
                        state <= init_done ? ST_IDLE : ST_INIT;
`else
                        state <= ST_IDLE;
`endif
                    end else timer <= timer - TW'(1);
                end
`ifdef LCD_INIT_EN
                ST_PWRUP: begin
                    if (timer == '0) begin
                        state    <= ST_INIT;
                        force_on <= 1'b1;
                    end else timer <= timer - TW'(1);
                end
                ST_INIT: begin
                    o_lcd_data <= INIT_ROM[init_idx];
                    o_lcd_rs   <= 1'b0;
                    init_idx   <= init_idx + 2'd1;
                    if (init_idx == 2'(INIT_LEN - 1)) init_done <= 1'b1;
                    state <= ST_SETUP;
                    timer <= LD_SETUP;
                end
`endif
                default: begin
                    state    <= ST_IDLE;
                    o_lcd_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
